// File: rtl/lander_pkg.sv
// Shared types and ASCII constants for the lander telemetry serialiser.
// LANDER_TELEM_CHECKSUM_EN selects the 34-byte frame with "*HH" checksum.
package lander_pkg;

   typedef enum logic [1:0] {IDLE, SEND, WAIT} telem_t;

   localparam logic [7:0] CH_PLUS   = 8'h2B;
   localparam logic [7:0] CH_MINUS  = 8'h2D;
   localparam logic [7:0] CH_ZERO   = 8'h30;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_LAND   = 8'h4C;
   localparam logic [7:0] CH_FAIL   = 8'h58;
   localparam logic [7:0] CH_NOMINAL = 8'h2E;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;

   // Field letters indexed by field number: 0=A, 1=V, 2=F, 3=T.
   localparam logic [3:0][7:0] FIELD_CH = {8'h54, 8'h46, 8'h56, 8'h41};

   localparam int LINE_BYTES_PLAIN = 31;
   localparam int LINE_BYTES_CSUM  = 34;
   localparam int STATUS_IDX       = 28;

`ifdef LANDER_TELEM_CHECKSUM_EN
   localparam int FRAME_BYTES = LINE_BYTES_CSUM;
`else
   localparam int FRAME_BYTES = LINE_BYTES_PLAIN;
`endif

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
   endfunction

endpackage

// File: rtl/lander_telemetry_tx_bcd_fmt.sv
// Formats one signed 4-digit BCD field into a sign char and four ASCII digits.
module bcd_field_fmt
   import lander_pkg::*;
(
   input  logic [15:0]     val_i,
   output logic [7:0]      sign_o,
   output logic [3:0][7:0] digit_o
);

   logic       neg;
   logic       carry;
   logic [3:0] nib;
   logic [4:0] sum;

   // Negative values: nines-complement each digit, then ripple a +1 in BCD.
   always_comb begin
      neg     = val_i[15];
      carry   = neg;
      nib     = 4'd0;
      sum     = 5'd0;
      sign_o  = neg ? CH_MINUS : CH_PLUS;
      digit_o = '0;
      for (int i = 0; i < 4; i++) begin
         nib = neg ? (4'd9 - val_i[4*i +: 4]) : val_i[4*i +: 4];
         sum = {1'b0, nib} + {4'b0, carry};
         if (sum == 5'd10) begin
            digit_o[i] = CH_ZERO;
            carry      = 1'b1;
         end else begin
            digit_o[i] = CH_ZERO + {4'b0, sum[3:0]};
            carry      = 1'b0;
         end
      end
   end

endmodule

// File: rtl/lander_telemetry_tx.sv
// Snapshots lander state and sends it as an ASCII line over the UART TX handshake.
// Define LANDER_TELEM_CHECKSUM_EN to append "*HH" (XOR of bytes 0..28) before CR LF.
module lander_telemetry_tx
   import lander_pkg::*;
#(
   parameter int LINE_BYTES = 31
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        sample_i,
   input  logic [15:0] alt_i,
   input  logic [15:0] vel_i,
   input  logic [15:0] fuel_i,
   input  logic [15:0] thrust_i,
   input  logic        land_i,
   input  logic        fail_i,
   input  logic        txready_i,
   output logic [7:0]  txdata_o,
   output logic        txclk_o,
   output logic        busy_o,
   output logic        frame_done_o,
   output telem_t      state_o
);

`ifdef LANDER_TELEM_CHECKSUM_EN
   localparam int FRAME_LEN = LINE_BYTES + (LINE_BYTES_CSUM - LINE_BYTES_PLAIN);
   logic [7:0] csum_q;
`else
   localparam int FRAME_LEN = LINE_BYTES;
`endif
   localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

   telem_t            state_q;
   logic [5:0]        idx_q;
   logic [3:0][15:0]  val_q;
   logic              land_q, fail_q;
   logic [7:0]        txdata_q;
   logic              txclk_q, busy_q, frame_done_q;
   logic [7:0]        char_d;
   logic [7:0]        sgn [4];
   logic [3:0][7:0]   dig [4];

   for (genvar g = 0; g < 4; g++) begin : g_fmt
      bcd_field_fmt u_fmt (.val_i(val_q[g]), .sign_o(sgn[g]), .digit_o(dig[g]));
   end

   // Fields occupy 7-byte slots: letter, sign, four digits, space.
   always_comb begin
      char_d = 8'h00;
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < 7; k++) begin
            if (idx_q == 6'(7*f + k)) begin
               case (k)
                  0:       char_d = FIELD_CH[f];
                  1:       char_d = sgn[f];
                  6:       char_d = CH_SPACE;
                  default: char_d = dig[f][5-k];
               endcase
            end
         end
      end
      if (idx_q == 6'(STATUS_IDX))
         char_d = land_q ? CH_LAND : (fail_q ? CH_FAIL : CH_NOMINAL);
`ifdef LANDER_TELEM_CHECKSUM_EN
      case (idx_q)
         6'd29:   char_d = CH_STAR;
         6'd30:   char_d = hex_char(csum_q[7:4]);
         6'd31:   char_d = hex_char(csum_q[3:0]);
         6'd32:   char_d = CH_CR;
         6'd33:   char_d = CH_LF;
         default: ;
      endcase
`else
      case (idx_q)
         6'd29:   char_d = CH_CR;
         6'd30:   char_d = CH_LF;
         default: ;
      endcase
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         val_q        <= '0;
         land_q       <= 1'b0;
         fail_q       <= 1'b0;
         txdata_q     <= 8'h00;
         txclk_q      <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef LANDER_TELEM_CHECKSUM_EN
         csum_q       <= 8'h00;
`endif
      end else begin
         txclk_q      <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A request coinciding with frame_done belongs to the old frame.
               if (sample_i && !frame_done_q) begin
                  val_q   <= {thrust_i, fuel_i, vel_i, alt_i};
                  land_q  <= land_i;
                  fail_q  <= fail_i;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SEND;
`ifdef LANDER_TELEM_CHECKSUM_EN
                  csum_q  <= 8'h00;
`endif
               end
            end
            SEND: begin
               if (txready_i) begin
                  txdata_q <= char_d;
                  txclk_q  <= 1'b1;
                  state_q  <= WAIT;
`ifdef LANDER_TELEM_CHECKSUM_EN
                  if (idx_q <= 6'(STATUS_IDX)) csum_q <= csum_q ^ char_d;
`endif
               end
            end
            WAIT: begin
               if (!txready_i) begin
                  if (idx_q == LAST_IDX) begin
                     state_q      <= IDLE;
                     busy_q       <= 1'b0;
                     frame_done_q <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + 6'd1;
                     state_q <= SEND;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign txdata_o     = txdata_q;
   assign txclk_o      = txclk_q;
   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;
   assign state_o      = state_q;

endmodule
